// File: rtl/delay_event_scheduler.sv
// Programmable delay line: changes on din are queued as timed events and
// replayed on dout after a per-event delay, with transport or inertial semantics.
module delay_event_scheduler #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int DLY_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           din,
  input  logic [DLY_W-1:0]           delay,
  input  logic                       mode,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic                       pending,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] din_q;
  logic [WIDTH-1:0] val_mem [DEPTH];
  logic [DLY_W-1:0] rem_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [DEPTH-1:0] slot_valid;
  logic             ev;
  logic             full;
  logic             do_pop;
  logic             push;
  logic             keep_new;
  logic [WIDTH-1:0] dout_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A slot is live when its distance from the read pointer (mod DEPTH) is below count.
  always_comb begin
    slot_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i >= int'(rd_ptr))
        slot_valid[i] = (i - int'(rd_ptr)) < int'(count);
      else
        slot_valid[i] = (i + DEPTH - int'(rd_ptr)) < int'(count);
    end
  end

  assign ev        = (din != din_q);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = (count != '0) && (rem_mem[rd_ptr] == '0) && !flush;
  assign dout_next = do_pop ? val_mem[rd_ptr] : dout;
  assign push      = ev && !flush && !mode && (!full || do_pop);
  // An inertial event is judged against dout as it stands after any same-edge pop.
  assign keep_new  = (din != dout_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q  <= '0;
      dout   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        val_mem[i] <= '0;
        rem_mem[i] <= '0;
      end
    end else begin
      din_q <= din;
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_valid[i] && rem_mem[i] != '0)
          rem_mem[i] <= rem_mem[i] - DLY_W'(1);
      end

      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else if (ev && mode) begin
        dout   <= dout_next;
        rd_ptr <= wr_ptr;
        if (keep_new) begin
          val_mem[wr_ptr] <= din;
          rem_mem[wr_ptr] <= delay;
          wr_ptr          <= ptr_inc(wr_ptr);
          count           <= CNT_W'(1);
        end else begin
          count <= '0;
        end
      end else begin
        dout <= dout_next;
        if (do_pop)
          rd_ptr <= ptr_inc(rd_ptr);
        if (push) begin
          val_mem[wr_ptr] <= din;
          rem_mem[wr_ptr] <= delay;
          wr_ptr          <= ptr_inc(wr_ptr);
        end
        if (ev && !push)
          ovf <= 1'b1;
        if (push && !do_pop)
          count <= count + CNT_W'(1);
        else if (!push && do_pop)
          count <= count - CNT_W'(1);
      end
    end
  end

  assign level   = count;
  assign pending = (count != '0);

endmodule

// File: tb/tb_delay_event_scheduler.sv
// Bench for delay_event_scheduler: an absolute-due-time event model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_delay_event_scheduler;

  localparam int WIDTH = 1;
  localparam int DEPTH = 8;
  localparam int DLY_W = 4;
  localparam int LW    = $clog2(DEPTH+1);

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic [DLY_W-1:0] delay;
  logic             mode;
  logic             flush;
  logic [WIDTH-1:0] dout;
  logic             pending;
  logic [LW-1:0]    level;
  logic             ovf;

  int n_vec  = 0;
  int n_miss = 0;
  int max_level = 0;

  delay_event_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .delay(delay), .mode(mode),
    .flush(flush), .dout(dout), .pending(pending), .level(level), .ovf(ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: each queued event carries the absolute edge number at which it is due
  typedef struct {
    logic [WIDTH-1:0] val;
    int               due;
  } ev_t;

  ev_t              mq[$];
  int               cyc;
  logic [WIDTH-1:0] m_dout;
  logic [WIDTH-1:0] m_dinq;
  logic             m_ovf;
  logic             m_ev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_dout = '0;
      m_dinq = '0;
      m_ovf  = 1'b0;
      cyc    = 0;
    end else begin
      cyc++;
      m_ev   = (din != m_dinq);
      m_dinq = din;
      if (flush) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          m_dout = mq[0].val;
          void'(mq.pop_front());
        end
        if (m_ev) begin
          if (mode) begin
            mq.delete();
            if (din != m_dout) mq.push_back('{din, cyc + 1 + int'(delay)});
          end else if (mq.size() < DEPTH) begin
            mq.push_back('{din, cyc + 1 + int'(delay)});
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("dout",    32'(dout),    32'(m_dout));
      chk("level",   32'(level),   32'(mq.size()));
      chk("pending", 32'(pending), 32'(mq.size() != 0));
      chk("ovf",     32'(ovf),     32'(m_ovf));
      if (int'(level) > max_level) max_level = int'(level);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; din = '0; delay = '0; mode = 1'b0; flush = 1'b0;
    tick(2);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    tick(2);

    // transport, delay 3
    delay = 4'd3; din = 1'b1;
    tick(1);
    chk("t1_level_e0", 32'(level), 1);
    chk("t1_dout_e0", 32'(dout), 0);
    tick(3);
    chk("t1_level_e3", 32'(level), 1);
    chk("t1_dout_e3", 32'(dout), 0);
    tick(1);
    chk("t1_dout_e4", 32'(dout), 1);
    chk("t1_level_e4", 32'(level), 0);

    // transport, delay 5, toggle every 2 cycles
    delay = 4'd5; max_level = 0;
    for (int i = 0; i < 6; i++) begin
      din = ~din;
      tick(2);
    end
    tick(8);
    chk("t2_level_peak", 32'(max_level), 3);
    chk("t2_ovf", 32'(ovf), 0);
    chk("t2_dout_end", 32'(dout), 1);

    // inertial, delay 4: bring dout low, then short and long pulses
    mode = 1'b1; delay = 4'd4; din = 1'b0;
    tick(6);
    chk("t3_dout_low", 32'(dout), 0);
    din = 1'b1;
    tick(2);
    chk("t3_short_level", 32'(level), 1);
    din = 1'b0;
    tick(1);
    chk("t3_short_cancel", 32'(level), 0);
    tick(6);
    chk("t3_short_dout", 32'(dout), 0);
    din = 1'b1;
    tick(5);
    chk("t3_long_e4", 32'(dout), 0);
    tick(1);
    chk("t3_long_e5", 32'(dout), 1);
    din = 1'b0;
    tick(1);
    chk("t3_long_e6", 32'(dout), 1);
    chk("t3_long_lvl", 32'(level), 1);
    tick(4);
    chk("t3_long_e10", 32'(dout), 1);
    tick(1);
    chk("t3_long_e11", 32'(dout), 0);

    // transport, delay 0: one-edge register
    mode = 1'b0; delay = 4'd0; max_level = 0;
    for (int i = 0; i < 8; i++) begin
      din = ~din;
      tick(1);
    end
    chk("t4_dout", 32'(dout), 1);
    tick(2);
    chk("t4_level_peak", 32'(max_level), 1);
    chk("t4_dout_end", 32'(dout), 0);

    // overflow, delay 15, toggle every cycle for 10 cycles
    delay = 4'd15;
    for (int i = 0; i < 10; i++) begin
      din = ~din;
      tick(1);
      if (i == 7) begin
        chk("t5_level_full", 32'(level), 8);
        chk("t5_ovf_pre", 32'(ovf), 0);
      end
      if (i == 8) chk("t5_ovf_set", 32'(ovf), 1);
    end
    chk("t5_level_end", 32'(level), 8);
    tick(7);
    chk("t5_first_pop", 32'(dout), 1);
    chk("t5_level_pop", 32'(level), 7);
    tick(10);
    chk("t5_drained", 32'(level), 0);
    chk("t5_ovf_sticky", 32'(ovf), 1);

    // flush with 3 queued and a same-edge event
    delay = 4'd10;
    for (int i = 0; i < 3; i++) begin
      din = ~din;
      tick(1);
    end
    chk("t6_level_pre", 32'(level), 3);
    flush = 1'b1; din = 1'b0;
    tick(1);
    flush = 1'b0;
    chk("t6_level", 32'(level), 0);
    chk("t6_dout", 32'(dout), 0);
    tick(14);
    chk("t6_dout_after", 32'(dout), 0);

    // asynchronous reset with 4 queued
    delay = 4'd0; din = 1'b1;
    tick(2);
    chk("t7_dout_hi", 32'(dout), 1);
    delay = 4'd10;
    for (int i = 0; i < 4; i++) begin
      din = ~din;
      tick(1);
    end
    chk("t7_level_pre", 32'(level), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_dout", 32'(dout), 0);
    chk("t7_rst_level", 32'(level), 0);
    chk("t7_rst_pending", 32'(pending), 0);
    chk("t7_rst_ovf", 32'(ovf), 0);
    din = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(15);
    chk("t7_quiet_dout", 32'(dout), 0);
    chk("t7_quiet_level", 32'(level), 0);
    din = 1'b1; delay = 4'd2;
    tick(4);
    chk("t7_new_event", 32'(dout), 1);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
